// File: rtl/morse_encoder_pkg.sv
// morse_encoder_pkg: shared definitions for the morse game datapath.
//   - Symbol codes (2 bits per symbol) reused by player2 and translator.
//   - Player 1 encoder FSM state type.
//   - Field widths of the packed word / RAM interface.
//   - classify_hold(): maps a hold length in ticks to a dot or dash.
package morse_encoder_pkg;

  localparam int unsigned WORD_W   = 10;  // five 2-bit symbols
  localparam int unsigned ADDR_W   = 4;   // ram32x10 player 1 window
  localparam int unsigned WCNT_W   = 5;   // 0..16 words
  localparam int unsigned SCNT_W   = 3;   // 0..5 symbols
  localparam int unsigned HOLD_W   = 3;   // saturating tick counter
  localparam int unsigned MAX_SYMS = 5;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_EMPTY = 2'b00;
  localparam sym_t SYM_DOT   = 2'b01;
  localparam sym_t SYM_DASH  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_COMMIT,
    S_FIN
  } state_t;

  function automatic sym_t classify_hold(input logic [HOLD_W-1:0] ticks,
                                         input int unsigned dash_ticks);
    return (32'(ticks) >= dash_ticks) ? SYM_DASH : SYM_DOT;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// morse_encoder_if: player 1 RAM write bus plus encoder status.
//   q          - packed symbol word (RAM data)
//   wren       - one-cycle RAM write strobe
//   addr       - RAM write address
//   word_count - words written so far (0..16)
//   sym_count  - symbols in the current word (0..5)
//   overflow   - a 6th symbol was dropped from the current word
//   finished   - player 1 input complete
// master: driven by morse_encoder; slave: RAM / top-level consumer.
interface morse_encoder_if;
  import morse_encoder_pkg::*;

  logic [WORD_W-1:0] q;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [WCNT_W-1:0] word_count;
  logic [SCNT_W-1:0] sym_count;
  logic              overflow;
  logic              finished;

  modport master (
    output q, wren, addr, word_count, sym_count, overflow, finished
  );

  modport slave (
    input q, wren, addr, word_count, sym_count, overflow, finished
  );

endinterface

// File: rtl/morse_encoder_key_sync.sv
// key_sync: two-flop synchronizer for an active-low asynchronous key,
// followed by a registered edge detector.
//   clock    - CLOCK_50
//   resetn   - synchronous active-low reset
//   pin_n    - raw key input, active low
//   pressed  - one-cycle pulse on the press (falling) edge
//   released - one-cycle pulse on the release (rising) edge
// Pin to pulse latency: 2 synchronizer cycles + 1 edge-register cycle.
module key_sync (
  input  logic clock,
  input  logic resetn,
  input  logic pin_n,
  output logic pressed,
  output logic released
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pressed_q, pressed_d;
  logic released_q, released_d;

  always_comb begin
    sync1_d    = pin_n;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    pressed_d  = prev_q & ~sync2_q;
    released_d = ~prev_q & sync2_q;
  end

  // Synchronizer resets to the idle (released) level so leaving reset
  // never fabricates an edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign pressed  = pressed_q;
  assign released = released_q;

endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: player 1 front end of the morse game.
// Turns key hold lengths into dot/dash symbols packed five to a 10-bit
// word and writes completed words into ram32x10.
//   clock   - CLOCK_50
//   resetn  - synchronous active-low reset
//   tick    - 2 Hz one-cycle enable from rate_divider
//   enable  - high while the top FSM is in S_P1TURN
//   key_n   - symbol key (hold length selects dot/dash), active low
//   next_n  - commit current word, active low
//   done_n  - commit current word (if any) and finish, active low
//   bus     - RAM write bus and status (morse_encoder_if.master)
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int unsigned DASH_TICKS = 3,
  parameter int unsigned MAX_WORDS  = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            tick,
  input  logic            enable,
  input  logic            key_n,
  input  logic            next_n,
  input  logic            done_n,
  morse_encoder_if.master bus
);

  localparam logic [WCNT_W-1:0] MAX_WC  = WCNT_W'(MAX_WORDS);
  localparam logic [SCNT_W-1:0] FULL_SC = SCNT_W'(MAX_SYMS);

  logic key_pressed, key_released;
  logic next_pressed, done_pressed;
  logic unused_next_released, unused_done_released;

  key_sync u_key_sync (
    .clock    (clock),
    .resetn   (resetn),
    .pin_n    (key_n),
    .pressed  (key_pressed),
    .released (key_released)
  );

  key_sync u_next_sync (
    .clock    (clock),
    .resetn   (resetn),
    .pin_n    (next_n),
    .pressed  (next_pressed),
    .released (unused_next_released)
  );

  key_sync u_done_sync (
    .clock    (clock),
    .resetn   (resetn),
    .pin_n    (done_n),
    .pressed  (done_pressed),
    .released (unused_done_released)
  );

  state_t state_q, state_d;

  logic [WORD_W-1:0] q_q, q_d;
  logic [SCNT_W-1:0] sym_count_q, sym_count_d;
  logic              overflow_q, overflow_d;
  logic [HOLD_W-1:0] hold_ticks_q, hold_ticks_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCNT_W-1:0] word_count_q, word_count_d;
  logic              from_done_q, from_done_d;

  logic [WCNT_W-1:0] word_inc;
  assign word_inc = word_count_q + WCNT_W'(1);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          // done beats next; a key press alongside either is dropped.
          if (done_pressed)
            state_d = (sym_count_q != '0) ? S_COMMIT : S_FIN;
          else if (next_pressed && (sym_count_q != '0))
            state_d = S_COMMIT;
          else if (key_pressed && !next_pressed)
            state_d = S_HOLD;
        end
        S_HOLD: begin
          if (key_released) state_d = S_WAIT;
        end
        S_COMMIT: begin
          state_d = (from_done_q || (word_inc == MAX_WC)) ? S_FIN : S_WAIT;
        end
        S_FIN:   state_d = S_FIN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-values
  always_comb begin
    q_d          = q_q;
    sym_count_d  = sym_count_q;
    overflow_d   = overflow_q;
    hold_ticks_d = hold_ticks_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    from_done_d  = from_done_q;

    if (!enable || (state_q == S_IDLE)) begin
      // Abandoning the turn discards any partial word.
      q_d          = {5{SYM_EMPTY}};
      sym_count_d  = '0;
      overflow_d   = 1'b0;
      hold_ticks_d = '0;
      addr_d       = '0;
      word_count_d = '0;
      from_done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (done_pressed || next_pressed)
            from_done_d = done_pressed;
          else if (key_pressed)
            hold_ticks_d = '0;
        end
        S_HOLD: begin
          // A tick coincident with the release is deliberately not counted.
          if (key_released) begin
            if (sym_count_q == FULL_SC) begin
              overflow_d = 1'b1;
            end else begin
              q_d         = {q_q[WORD_W-3:0], classify_hold(hold_ticks_q, DASH_TICKS)};
              sym_count_d = sym_count_q + SCNT_W'(1);
            end
          end else if (tick && (hold_ticks_q != '1)) begin
            hold_ticks_d = hold_ticks_q + HOLD_W'(1);
          end
        end
        S_COMMIT: begin
          q_d          = {5{SYM_EMPTY}};
          sym_count_d  = '0;
          overflow_d   = 1'b0;
          word_count_d = word_inc;
          // Hold the last address instead of wrapping past the window.
          if (word_inc < MAX_WC) addr_d = addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      q_q          <= '0;
      sym_count_q  <= '0;
      overflow_q   <= 1'b0;
      hold_ticks_q <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      from_done_q  <= 1'b0;
    end else begin
      q_q          <= q_d;
      sym_count_q  <= sym_count_d;
      overflow_q   <= overflow_d;
      hold_ticks_q <= hold_ticks_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      from_done_q  <= from_done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.q          = q_q;
    bus.sym_count  = sym_count_q;
    bus.overflow   = overflow_q;
    bus.addr       = addr_q;
    bus.word_count = word_count_q;
    bus.wren       = (state_q == S_COMMIT);
    bus.finished   = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_morse_encoder.sv
module tb_morse_encoder;

  logic clock = 1'b0;
  logic resetn, tick, enable, key_n, next_n, done_n;

  morse_encoder_if bus ();

  morse_encoder #(.DASH_TICKS(3), .MAX_WORDS(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick),
    .enable (enable),
    .key_n  (key_n),
    .next_n (next_n),
    .done_n (done_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [24:0] all_out;
  assign all_out = {bus.q, bus.wren, bus.addr, bus.word_count,
                    bus.sym_count, bus.overflow, bus.finished};

  int tests_run = 0;
  int tests_failed = 0;

  // Write-strobe monitor, sampled on the inactive edge.
  int         wren_cnt = 0;
  logic [9:0] last_q;
  logic [3:0] last_addr;
  always @(negedge clock) begin
    if (bus.wren === 1'b1) begin
      wren_cnt  = wren_cnt + 1;
      last_q    = bus.q;
      last_addr = bus.addr;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; tick = 1'b0;
    key_n = 1'b1; next_n = 1'b1; done_n = 1'b1;
    cycles(3);
    resetn = 1'b1;
    cycles(1);
    enable = 1'b1;
    cycles(2);
    wren_cnt = 0;
  endtask

  // Hold the symbol key for n ticks, then release and let it settle.
  task automatic send_symbol(input int n);
    key_n = 1'b0;
    cycles(5);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cycles(1);
      tick = 1'b0; cycles(1);
    end
    key_n = 1'b1;
    cycles(5);
  endtask

  task automatic press_next();
    next_n = 1'b0; cycles(6);
    next_n = 1'b1; cycles(4);
  endtask

  task automatic press_done();
    done_n = 1'b0; cycles(6);
    done_n = 1'b1; cycles(4);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; tick = 1'b1;
    key_n = 1'b0; next_n = 1'b0; done_n = 1'b0;
    cycles(3);
    tests_run++;
    if (all_out !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    key_n = 1'b1; next_n = 1'b1; done_n = 1'b1; tick = 1'b0;
    enable = 1'b0;
    resetn = 1'b1;
    cycles(4);
    tests_run++;
    if (all_out !== 25'd0) begin
      tests_failed++;
      $display("FAIL idle_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_dot_dash_dot();
    do_reset();
    send_symbol(1); send_symbol(4); send_symbol(1);
    tests_run++;
    if (bus.q !== 10'b00_00_01_11_01 || bus.sym_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL ddd_word: got q=%b sc=%0d expected q=0000011101 sc=3", bus.q, bus.sym_count);
    end
    press_next();
    tests_run++;
    if (wren_cnt !== 1 || last_q !== 10'b00_00_01_11_01 || last_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL ddd_write: got n=%0d q=%b a=%0d expected n=1 q=0000011101 a=0", wren_cnt, last_q, last_addr);
    end
    tests_run++;
    if (bus.addr !== 4'd1 || bus.word_count !== 5'd1 || bus.q !== 10'd0 || bus.sym_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL ddd_after: got a=%0d wc=%0d q=%b sc=%0d expected 1 1 0 0", bus.addr, bus.word_count, bus.q, bus.sym_count);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    send_symbol(2); send_symbol(3); send_symbol(9);
    tests_run++;
    if (bus.q !== 10'b00_00_01_11_11 || bus.sym_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL threshold: got q=%b sc=%0d expected q=0000011111 sc=3", bus.q, bus.sym_count);
    end
  endtask

  task automatic test_six_dots();
    do_reset();
    for (int i = 0; i < 5; i++) send_symbol(1);
    tests_run++;
    if (bus.overflow !== 1'b0 || bus.sym_count !== 3'd5) begin
      tests_failed++;
      $display("FAIL five_dots: got ov=%b sc=%0d expected ov=0 sc=5", bus.overflow, bus.sym_count);
    end
    send_symbol(1);
    tests_run++;
    if (bus.q !== 10'b01_01_01_01_01 || bus.sym_count !== 3'd5 || bus.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL six_dots: got q=%b sc=%0d ov=%b expected q=0101010101 sc=5 ov=1", bus.q, bus.sym_count, bus.overflow);
    end
    press_next();
    tests_run++;
    if (wren_cnt !== 1 || last_q !== 10'b01_01_01_01_01 || bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got n=%0d q=%b ov=%b expected n=1 q=0101010101 ov=0", wren_cnt, last_q, bus.overflow);
    end
  endtask

  task automatic test_empty_next_done();
    do_reset();
    press_next();
    tests_run++;
    if (wren_cnt !== 0 || bus.finished !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_next: got n=%0d fin=%b expected n=0 fin=0", wren_cnt, bus.finished);
    end
    send_symbol(3);
    press_done();
    tests_run++;
    if (wren_cnt !== 1 || last_q !== 10'b00_00_00_00_11 || last_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL done_write: got n=%0d q=%b a=%0d expected n=1 q=0000000011 a=0", wren_cnt, last_q, last_addr);
    end
    tests_run++;
    if (bus.finished !== 1'b1 || bus.word_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL done_fin: got fin=%b wc=%0d expected fin=1 wc=1", bus.finished, bus.word_count);
    end
    do_reset();
    press_done();
    tests_run++;
    if (wren_cnt !== 0 || bus.finished !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_done: got n=%0d fin=%b expected n=0 fin=1", wren_cnt, bus.finished);
    end
  endtask

  task automatic test_fill();
    int prev;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_symbol(1);
      prev = wren_cnt;
      press_next();
      tests_run++;
      if (wren_cnt !== prev + 1 || last_addr !== 4'(i) || last_q !== 10'b00_00_00_00_01) begin
        tests_failed++;
        $display("FAIL fill_write%0d: got n=%0d a=%0d q=%b expected n=%0d a=%0d q=0000000001",
                 i, wren_cnt, last_addr, last_q, prev + 1, i);
      end
    end
    tests_run++;
    if (bus.word_count !== 5'd16 || bus.finished !== 1'b1 || bus.addr !== 4'd15) begin
      tests_failed++;
      $display("FAIL fill_end: got wc=%0d fin=%b a=%0d expected wc=16 fin=1 a=15", bus.word_count, bus.finished, bus.addr);
    end
    send_symbol(1); press_next(); press_done();
    tests_run++;
    if (wren_cnt !== 16 || bus.sym_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL fill_ignore: got n=%0d sc=%0d expected n=16 sc=0", wren_cnt, bus.sym_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_symbol(1); send_symbol(1);
    next_n = 1'b0; done_n = 1'b0;
    cycles(6);
    next_n = 1'b1; done_n = 1'b1;
    cycles(4);
    tests_run++;
    if (wren_cnt !== 1 || last_q !== 10'b00_00_00_01_01 || bus.finished !== 1'b1) begin
      tests_failed++;
      $display("FAIL simultaneous: got n=%0d q=%b fin=%b expected n=1 q=0000000101 fin=1", wren_cnt, last_q, bus.finished);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    send_symbol(1); send_symbol(1); send_symbol(1);
    key_n = 1'b0;
    cycles(5);
    tick = 1'b1; cycles(1);
    tick = 1'b0; cycles(1);
    enable = 1'b0;
    cycles(1);
    tests_run++;
    if (all_out !== 25'd0) begin
      tests_failed++;
      $display("FAIL enable_drop: got %h expected 0", all_out);
    end
    key_n = 1'b1;
    cycles(6);
    tests_run++;
    if (wren_cnt !== 0 || all_out !== 25'd0) begin
      tests_failed++;
      $display("FAIL enable_drop_quiet: got n=%0d out=%h expected n=0 out=0", wren_cnt, all_out);
    end
  endtask

  task automatic test_reset_commit();
    int  waited;
    bit  seen;
    do_reset();
    send_symbol(1);
    next_n = 1'b0;
    seen = 0;
    waited = 0;
    while (!seen && waited < 12) begin
      @(negedge clock);
      waited++;
      if (bus.wren === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL commit_timeout: got no wren within 12 cycles expected wren");
    end
    resetn = 1'b0;
    next_n = 1'b1;
    cycles(1);
    tests_run++;
    if (all_out !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_in_commit: got %h expected 0", all_out);
    end
    cycles(1);
    resetn = 1'b1;
    cycles(8);
    tests_run++;
    if (wren_cnt !== 1 || bus.word_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_commit_quiet: got n=%0d wc=%0d expected n=1 wc=0", wren_cnt, bus.word_count);
    end
  endtask

  initial begin
    test_reset();
    test_dot_dash_dot();
    test_threshold();
    test_six_dots();
    test_empty_next_done();
    test_fill();
    test_simultaneous();
    test_enable_drop();
    test_reset_commit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
